// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, error bit positions, default timing.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_state_t;

    localparam int ERR_FRAMING = 0;
    localparam int ERR_PARITY  = 1;
    localparam int ERR_TIMEOUT = 2;

    localparam int DEFAULT_CLK_DIV = 1433;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: restarts on a qualified start edge and strobes at mid-bit while running.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic run,
    output logic sample
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (restart) begin
            cnt_reg <= '0;
        end else if (run) begin
            if (cnt_reg == CW'(CLK_DIV - 1))
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign sample = run && !restart && (cnt_reg == CW'(CLK_DIV / 2));

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver that assembles FRAME_BYTES accepted bytes into a frame, with inter-byte timeout.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_DIV      = DEFAULT_CLK_DIV,
    parameter int FRAME_BYTES  = 6,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rxd,
    input  logic                     rx_en,
    output logic [7:0]               byte_data,
    output logic                     byte_valid,
    output logic [8*FRAME_BYTES-1:0] frame_data,
    output logic                     frame_valid,
    output logic [2:0]               err,
    output logic                     busy
);

    localparam int IW         = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int TMO_CYCLES = TIMEOUT_BITS * CLK_DIV;
    localparam int TW         = $clog2(TMO_CYCLES + 1);

    uart_state_t state_reg, state_next;

    logic                     sync1_reg, sync2_reg, prev_reg;
    logic [2:0]               bit_cnt_reg;
    logic [7:0]               shift_reg;
    logic                     par_bad_reg;
    logic [IW-1:0]            idx_reg;
    logic [TW-1:0]            tmo_cnt_reg;
    logic [8*FRAME_BYTES-1:0] frame_buf_reg, frame_buf_upd, frame_data_reg;
    logic [7:0]               byte_data_reg;
    logic                     byte_valid_reg, frame_valid_reg;
    logic [2:0]               err_reg;

    logic start_go, bit_sample, shift_en, accept, frame_err, par_err;
    logic tmo_run, tmo_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
        end else begin
            sync1_reg <= rxd;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign start_go = (state_reg == ST_IDLE) && prev_reg && !sync2_reg && rx_en;
    assign busy     = (state_reg != ST_IDLE);

    uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (start_go),
        .run     (busy),
        .sample  (bit_sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        shift_en   = 1'b0;
        accept     = 1'b0;
        frame_err  = 1'b0;
        par_err    = 1'b0;
        case (state_reg)
            ST_IDLE:  if (start_go) state_next = ST_START;
            ST_START: if (bit_sample) state_next = sync2_reg ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (bit_sample) begin
                    shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt_reg == 3'd7) state_next = ST_PARITY;
`else
                    if (bit_cnt_reg == 3'd7) state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_sample) begin
                    par_err    = (sync2_reg != ^shift_reg);
                    state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_sample) begin
                    accept     = sync2_reg && !par_bad_reg;
                    frame_err  = !sync2_reg;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Candidate frame with the current shift register dropped into the active slot
    for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_slot
        assign frame_buf_upd[8*gi +: 8] = (idx_reg == IW'(gi)) ? shift_reg
                                                                : frame_buf_reg[8*gi +: 8];
    end

    assign tmo_run    = (idx_reg != '0) && (state_reg == ST_IDLE);
    assign tmo_expire = tmo_run && (tmo_cnt_reg == TW'(TMO_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg     <= '0;
            shift_reg       <= '0;
            par_bad_reg     <= 1'b0;
            idx_reg         <= '0;
            tmo_cnt_reg     <= '0;
            frame_buf_reg   <= '0;
            frame_data_reg  <= '0;
            byte_data_reg   <= '0;
            byte_valid_reg  <= 1'b0;
            frame_valid_reg <= 1'b0;
            err_reg         <= '0;
        end else begin
            byte_valid_reg  <= accept;
            frame_valid_reg <= 1'b0;
            err_reg         <= '0;
            err_reg[ERR_FRAMING] <= frame_err;
            err_reg[ERR_PARITY]  <= par_err;
            err_reg[ERR_TIMEOUT] <= tmo_expire;

            if (start_go) begin
                bit_cnt_reg <= '0;
                par_bad_reg <= 1'b0;
            end else if (shift_en) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                shift_reg   <= {sync2_reg, shift_reg[7:1]};
            end
            if (par_err)
                par_bad_reg <= 1'b1;

            tmo_cnt_reg <= (tmo_run && !tmo_expire) ? tmo_cnt_reg + 1'b1 : '0;

            // Any error discards the partial frame; timeout only fires while IDLE
            if (frame_err || par_err || tmo_expire) begin
                idx_reg <= '0;
            end else if (accept) begin
                byte_data_reg <= shift_reg;
                frame_buf_reg <= frame_buf_upd;
                if (idx_reg == IW'(FRAME_BYTES - 1)) begin
                    idx_reg         <= '0;
                    frame_data_reg  <= frame_buf_upd;
                    frame_valid_reg <= 1'b1;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end

    assign byte_data   = byte_data_reg;
    assign byte_valid  = byte_valid_reg;
    assign frame_data  = frame_data_reg;
    assign frame_valid = frame_valid_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with CLK_DIV=16, FRAME_BYTES=3, TIMEOUT_BITS=4.
module tb_uart_rx_frame;

    localparam int CLK_DIV      = 16;
    localparam int FRAME_BYTES  = 3;
    localparam int TIMEOUT_BITS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd = 1'b1;
    logic        rx_en = 1'b1;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic [23:0] frame_data;
    logic        frame_valid;
    logic [2:0]  err;
    logic        busy;

    always #5 clk = ~clk;

    uart_rx_frame #(
        .CLK_DIV      (CLK_DIV),
        .FRAME_BYTES  (FRAME_BYTES),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .rx_en       (rx_en),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .err         (err),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Event monitor: counts pulses, remembers last byte/frame
    int          n_byte = 0, n_frame = 0, n_e0 = 0, n_e1 = 0, n_e2 = 0;
    logic [7:0]  last_byte = 8'h00;
    logic [23:0] last_frame = 24'h0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid) begin
                n_byte++;
                last_byte = byte_data;
                $display("rx byte 0x%02h", byte_data);
            end
            if (frame_valid) begin
                n_frame++;
                last_frame = frame_data;
                $display("rx frame 0x%06h", frame_data);
            end
            if (err[0]) n_e0++;
            if (err[1]) n_e1++;
            if (err[2]) n_e2++;
        end
    end

    int s_byte, s_frame, s_e0, s_e1, s_e2;

    task automatic snap();
        s_byte  = n_byte;
        s_frame = n_frame;
        s_e0    = n_e0;
        s_e1    = n_e1;
        s_e2    = n_e2;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_good);
        $display("tx byte 0x%02h stop=%0d par_good=%0d", b, stop_bit, par_good);
        rxd = 1'b0;
        idle(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(CLK_DIV);
        end
`ifdef UART_RX_PARITY_EN
        rxd = par_good ? ^b : ~^b;
        idle(CLK_DIV);
`endif
        rxd = stop_bit;
        idle(CLK_DIV);
        rxd = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic saw_busy;

    initial begin
        // Reset state
        idle(3);
        check("rst_byte_data", byte_data, 8'h00);
        check("rst_frame_data", frame_data, 24'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 3'b000);
        check("rst_byte_valid", byte_valid, 1'b0);
        check("rst_frame_valid", frame_valid, 1'b0);
        rst_n = 1'b1;
        idle(5);

        // Three back-to-back bytes form one frame
        snap();
        send_byte(8'h11, 1'b1, 1'b1);
        send_byte(8'h22, 1'b1, 1'b1);
        send_byte(8'h33, 1'b1, 1'b1);
        idle(20);
        check("b2b_bytes", n_byte - s_byte, 3);
        check("b2b_last_byte", last_byte, 8'h33);
        check("b2b_frames", n_frame - s_frame, 1);
        check("b2b_frame", last_frame, 24'h332211);
        check("b2b_errs", (n_e0 - s_e0) + (n_e2 - s_e2), 0);

        // Start glitch of 5 cycles
        snap();
        saw_busy = 1'b0;
        rxd = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        rxd = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
            else break;
        end
        check("glitch_saw_busy", saw_busy, 1'b1);
        check("glitch_busy_clear", busy, 1'b0);
        idle(40);
        check("glitch_no_byte", n_byte - s_byte, 0);

        // Framing error discards the partial frame
        snap();
        send_byte(8'h99, 1'b1, 1'b1);
        send_byte(8'hA5, 1'b0, 1'b1);
        idle(CLK_DIV);
        check("ferr_pulse", n_e0 - s_e0, 1);
        check("ferr_bytes", n_byte - s_byte, 1);
        send_byte(8'h44, 1'b1, 1'b1);
        send_byte(8'h55, 1'b1, 1'b1);
        send_byte(8'h66, 1'b1, 1'b1);
        idle(20);
        check("ferr_frames", n_frame - s_frame, 1);
        check("ferr_frame", last_frame, 24'h665544);

        // Inter-byte timeout
        snap();
        send_byte(8'h01, 1'b1, 1'b1);
        send_byte(8'h02, 1'b1, 1'b1);
        idle(70);
        check("tmo_pulse", n_e2 - s_e2, 1);
        check("tmo_bytes", n_byte - s_byte, 2);
        check("tmo_no_frame", n_frame - s_frame, 0);
        send_byte(8'h0A, 1'b1, 1'b1);
        send_byte(8'h0B, 1'b1, 1'b1);
        send_byte(8'h0C, 1'b1, 1'b1);
        idle(20);
        check("tmo_frames", n_frame - s_frame, 1);
        check("tmo_frame", last_frame, 24'h0C0B0A);

        // rx_en gating
        snap();
        rx_en = 1'b0;
        send_byte(8'h55, 1'b1, 1'b1);
        idle(20);
        check("rxen_blocked", n_byte - s_byte, 0);
        check("rxen_idle_busy", busy, 1'b0);
        rx_en = 1'b1;
        idle(5);
        fork
            send_byte(8'h66, 1'b1, 1'b1);
            begin
                idle(3 * CLK_DIV);
                rx_en = 1'b0;
            end
        join
        idle(20);
        check("rxen_mid_bytes", n_byte - s_byte, 1);
        check("rxen_mid_data", last_byte, 8'h66);
        rx_en = 1'b1;
        idle(150);

`ifdef UART_RX_PARITY_EN
        // Parity mismatch discards the byte
        snap();
        send_byte(8'h07, 1'b1, 1'b0);
        idle(20);
        check("par_pulse", n_e1 - s_e1, 1);
        check("par_no_byte", n_byte - s_byte, 0);
        check("par_no_ferr", n_e0 - s_e0, 0);
        send_byte(8'h07, 1'b1, 1'b1);
        idle(20);
        check("par_good_byte", n_byte - s_byte, 1);
        check("par_good_data", last_byte, 8'h07);
`else
        check("par_tied_zero", n_e1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1433, clk cycles per bit period (min 8).
REQ-002 SHALL have parameter FRAME_BYTES, default 6, bytes per assembled frame (1..16).
REQ-003 SHALL have parameter TIMEOUT_BITS, default 20, max idle gap in bit periods between bytes of one frame.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port rxd  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_en  input  1  high enables acceptance of new start bits.
REQ-008 SHALL have port byte_data  output  8  last received byte.
REQ-009 SHALL have port byte_valid  output  1  one-cycle pulse when byte_data updates.
REQ-010 SHALL have port frame_data  output  8*FRAME_BYTES  assembled frame, byte k at [8k+7:8k].
REQ-011 SHALL have port frame_valid  output  1  one-cycle pulse when frame_data updates.
REQ-012 SHALL have port err  output  3  one-cycle error pulses: [0] framing, [1] parity, [2] timeout.
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-014 rxd SHALL pass a 2-flop synchroniser; start detection is a falling edge on the synchronised line.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-016 IDLE->START on falling edge with rx_en=1; falling edges while rx_en=0 are ignored.
REQ-017 Bit counter SHALL restart at 0 on each edge-qualified start and sample at count CLK_DIV/2 (integer), wrap at CLK_DIV-1.
REQ-018 START: sample low -> DATA; sample high (glitch) -> IDLE, no pulse.
REQ-019 DATA: 8 samples, LSB first, then STOP (or PARITY).
REQ-020 STOP: sample high -> byte accepted, byte_valid pulses the cycle after the sample, FSM -> IDLE; sample low -> err[0] pulse, byte discarded, partial frame discarded, FSM -> IDLE.
REQ-021 Accepted byte SHALL be written to frame slot given by byte index 0..FRAME_BYTES-1; index wraps to 0 after the last slot.
REQ-022 frame_data and frame_valid SHALL update in the same cycle as byte_valid for the final slot; frame_data holds until the next complete frame.
REQ-023 Timeout counter SHALL run only while byte index != 0 and FSM is IDLE; reaching TIMEOUT_BITS*CLK_DIV cycles pulses err[2] and resets index to 0.
REQ-024 rx_en deassertion mid-byte SHALL NOT abort the byte; it blocks only the next start.
REQ-025 A start edge on the same cycle as timeout expiry SHALL apply the timeout first; the new byte lands in slot 0.
REQ-026 With FRAME_BYTES=1 every accepted byte SHALL pulse both byte_valid and frame_valid.

Reset
REQ-027 On rst_n low: FSM IDLE, counters and byte index 0, synchroniser flops 1, byte_data/frame_data 0, all pulses and busy 0.
REQ-028 Reset mid-byte SHALL discard the byte and partial frame; no pulse on release.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: PARITY state samples one even-parity bit after DATA; mismatch pulses err[1] and discards byte and partial frame, STOP still sampled.
REQ-030 Macro absent: no PARITY state, err[1] tied 0, frame is 10 bit periods.

Structure
REQ-031 Shared package uart_pkg SHALL hold FSM state enum, error-bit index constants and default CLK_DIV.
REQ-032 Sub-module uart_bit_timer (bit counter, mid-sample strobe) SHALL be instantiated once.

Verification (CLK_DIV=16, FRAME_BYTES=3, TIMEOUT_BITS=4)
REQ-033 Bytes 0x11,0x22,0x33 back-to-back -> three byte_valid; frame_valid once with frame_data=0x332211.
REQ-034 Low pulse of 5 cycles on rxd -> no pulse, busy returns 0 within 9 cycles.
REQ-035 Byte 0xA5 with stop bit low -> err[0] pulse, no byte_valid, next frame starts at slot 0.
REQ-036 Bytes 0x01,0x02 then 70-cycle idle -> err[2] pulse; then 0x0A,0x0B,0x0C -> frame_data=0x0C0B0A.
REQ-037 rx_en=0 during start edge of 0x55 -> no pulse; rx_en dropped mid-byte of 0x66 -> byte_valid with 0x66.
REQ-038 Macro defined, 0x07 sent with parity bit 0 -> err[1] pulse, no byte_valid.
